bayer_mosaic: RTL and testbench

- Re-mosaics a demosaiced RGB pixel stream back into a single-channel Bayer raw stream, the inverse of the interp_bilinear/interp_ed demosaic blocks.
- Output uses the same dvi/dtype/16-bit data protocol that the demosaic blocks consume. It can therefore feed them directly for loopback regression.
- Sits after RGB processing stages, for sensor-emulation and round-trip testing.
- Also reports the measured frame geometry and sticky protocol errors.

---
 rtl/bayer_mosaic_if.sv | 34 +++
 rtl/bayer_mosaic.sv | 161 ++++++++++++++++
 tb/tb_bayer_mosaic.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/bayer_mosaic_if.sv
// Stream bundle for the Bayer re-mosaic block: RGB/meta words in,
// single-channel raw words out, both using the dvi/dtype framing.
`ifndef DTYPE_FRAME_START
`define DTYPE_WIDTH       4
`define DTYPE_FRAME_START 4'h1
`define DTYPE_ROW_START   4'h2
`define DTYPE_ROW_END     4'h3
`define DTYPE_FRAME_END   4'h4
`define DTYPE_PIXEL       4'h5
`endif

interface bayer_mosaic_if #(
   parameter int PIXEL_WIDTH = 10
);
   logic                    dvi;
   logic [`DTYPE_WIDTH-1:0] dtypei;
   logic [PIXEL_WIDTH-1:0]  r;
   logic [PIXEL_WIDTH-1:0]  g;
   logic [PIXEL_WIDTH-1:0]  b;
   logic [15:0]             meta_datai;
   logic                    dvo;
   logic [`DTYPE_WIDTH-1:0] dtypeo;
   logic [15:0]             datao;

   modport master (
      output dvi, dtypei, r, g, b, meta_datai,
      input  dvo, dtypeo, datao
   );

   modport slave (
      input  dvi, dtypei, r, g, b, meta_datai,
      output dvo, dtypeo, datao
   );
endinterface

// File: rtl/bayer_mosaic.sv
// RGB to Bayer raw re-mosaic with frame geometry measurement and
// sticky protocol error reporting. One cycle latency, no backpressure.
module bayer_mosaic #(
   parameter int PIXEL_WIDTH = 10,
   parameter int DIM_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [1:0]           phase,
   bayer_mosaic_if.slave        s,
   output logic [DIM_WIDTH-1:0] num_cols,
   output logic [DIM_WIDTH-1:0] num_rows,
   output logic                 protocol_err
);

   typedef enum logic [1:0] {
      IDLE,
      IN_FRAME,
      IN_ROW
   } state_e;

   state_e                  state_q;
   logic [1:0]              phase_q;
   logic                    row_par_q;
   logic                    col_par_q;
   logic [DIM_WIDTH-1:0]    row_cnt_q;
   logic [DIM_WIDTH-1:0]    col_cnt_q;
   logic [DIM_WIDTH-1:0]    num_cols_q;
   logic [DIM_WIDTH-1:0]    num_rows_q;
   logic                    err_q;
   logic                    dvo_q;
   logic [`DTYPE_WIDTH-1:0] dtypeo_q;
   logic [15:0]             datao_q;

   logic                    is_fs;
   logic                    is_rs;
   logic                    is_re;
   logic                    is_fe;
   logic                    is_px;
   logic [1:0]              idx_d;
   logic [PIXEL_WIDTH-1:0]  pix_d;
   logic [15:0]             dat_d;
   logic                    fwd_d;

   function automatic logic [DIM_WIDTH-1:0] sat_inc(
      input logic [DIM_WIDTH-1:0] v
   );
      return (&v) ? v : v + 1'b1;
   endfunction

   assign is_fs = s.dtypei == `DTYPE_FRAME_START;
   assign is_rs = s.dtypei == `DTYPE_ROW_START;
   assign is_re = s.dtypei == `DTYPE_ROW_END;
   assign is_fe = s.dtypei == `DTYPE_FRAME_END;
   assign is_px = s.dtypei == `DTYPE_PIXEL;

   always_comb begin
      idx_d = phase_q ^ {row_par_q, col_par_q};
      pix_d = s.g;
      unique case (idx_d)
         2'd0:    pix_d = s.r;
         2'd3:    pix_d = s.b;
         default: pix_d = s.g;
      endcase
      dat_d = is_px ? 16'(pix_d) : s.meta_datai;
   end

   // Stray pixels outside a row are the only in-frame words not forwarded
   always_comb begin
      fwd_d = 1'b0;
      if (s.dvi) begin
         if (is_fs)
            fwd_d = enable;
         else if (state_q == IN_FRAME)
            fwd_d = !is_px;
         else if (state_q == IN_ROW)
            fwd_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         phase_q    <= 2'd0;
         row_par_q  <= 1'b0;
         col_par_q  <= 1'b0;
         row_cnt_q  <= '0;
         col_cnt_q  <= '0;
         num_cols_q <= '0;
         num_rows_q <= '0;
         err_q      <= 1'b0;
         dvo_q      <= 1'b0;
         dtypeo_q   <= '0;
         datao_q    <= '0;
      end else begin
         dvo_q <= fwd_d;
         if (fwd_d) begin
            dtypeo_q <= s.dtypei;
            datao_q  <= dat_d;
         end
         if (s.dvi && is_fs) begin
            // A restart flags an error even when it is accepted
            if (state_q != IDLE)
               err_q <= 1'b1;
            else if (enable)
               err_q <= 1'b0;
            if (enable) begin
               state_q   <= IN_FRAME;
               phase_q   <= phase;
               row_par_q <= 1'b0;
               row_cnt_q <= '0;
            end else begin
               state_q <= IDLE;
            end
         end else if (s.dvi) begin
            unique case (state_q)
               IN_FRAME: begin
                  if (is_rs) begin
                     state_q   <= IN_ROW;
                     col_par_q <= 1'b0;
                     col_cnt_q <= '0;
                  end else if (is_fe) begin
                     state_q    <= IDLE;
                     num_rows_q <= row_cnt_q;
                  end else if (is_px) begin
                     err_q <= 1'b1;
                  end
               end
               IN_ROW: begin
                  if (is_px) begin
                     col_par_q <= ~col_par_q;
                     col_cnt_q <= sat_inc(col_cnt_q);
                  end else if (is_re) begin
                     state_q    <= IN_FRAME;
                     row_par_q  <= ~row_par_q;
                     row_cnt_q  <= sat_inc(row_cnt_q);
                     num_cols_q <= col_cnt_q;
                     if (row_cnt_q != '0 && col_cnt_q != num_cols_q)
                        err_q <= 1'b1;
                  end else if (is_fe) begin
                     state_q    <= IDLE;
                     err_q      <= 1'b1;
                     row_cnt_q  <= sat_inc(row_cnt_q);
                     num_rows_q <= sat_inc(row_cnt_q);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign s.dvo        = dvo_q;
   assign s.dtypeo     = dtypeo_q;
   assign s.datao      = datao_q;
   assign num_cols     = num_cols_q;
   assign num_rows     = num_rows_q;
   assign protocol_err = err_q;

endmodule

// File: tb/tb_bayer_mosaic.sv
// Directed-vector bench for bayer_mosaic with hand-computed expectations.
`ifndef DTYPE_FRAME_START
`define DTYPE_WIDTH       4
`define DTYPE_FRAME_START 4'h1
`define DTYPE_ROW_START   4'h2
`define DTYPE_ROW_END     4'h3
`define DTYPE_FRAME_END   4'h4
`define DTYPE_PIXEL       4'h5
`endif

module tb_bayer_mosaic;

   localparam logic [`DTYPE_WIDTH-1:0] FS = `DTYPE_FRAME_START;
   localparam logic [`DTYPE_WIDTH-1:0] RS = `DTYPE_ROW_START;
   localparam logic [`DTYPE_WIDTH-1:0] RE = `DTYPE_ROW_END;
   localparam logic [`DTYPE_WIDTH-1:0] FE = `DTYPE_FRAME_END;
   localparam logic [`DTYPE_WIDTH-1:0] PX = `DTYPE_PIXEL;
   localparam logic [`DTYPE_WIDTH-1:0] HD = 4'hC;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [1:0]  phase;
   logic [15:0] num_cols;
   logic [15:0] num_rows;
   logic        protocol_err;

   int n_chk;
   int n_pass;

   bayer_mosaic_if #(.PIXEL_WIDTH(10)) bif ();

   bayer_mosaic #(
      .PIXEL_WIDTH(10),
      .DIM_WIDTH  (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .phase       (phase),
      .s           (bif.slave),
      .num_cols    (num_cols),
      .num_rows    (num_rows),
      .protocol_err(protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic idle();
      bif.dvi = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input string tag,
                       input logic [`DTYPE_WIDTH-1:0] dt,
                       input logic [15:0] meta,
                       input logic exp_dv,
                       input logic [15:0] exp_d);
      bif.dvi        = 1'b1;
      bif.dtypei     = dt;
      bif.meta_datai = meta;
      @(posedge clk);
      #1;
      bif.dvi = 1'b0;
      chk({tag, ".dvo"}, 32'(bif.dvo), 32'(exp_dv));
      if (exp_dv) begin
         chk({tag, ".dtype"}, 32'(bif.dtypeo), 32'(dt));
         chk({tag, ".data"}, 32'(bif.datao), 32'(exp_d));
      end
   endtask

   task automatic set_rgb(input logic [9:0] rv, input logic [9:0] gv,
                          input logic [9:0] bv);
      bif.r = rv;
      bif.g = gv;
      bif.b = bv;
   endtask

   logic [15:0] exp44 [0:1][0:3];
   logic [15:0] exp22 [1:3][0:3];

   initial begin
      n_chk          = 0;
      n_pass         = 0;
      reset          = 1'b1;
      enable         = 1'b1;
      phase          = 2'd0;
      bif.dvi        = 1'b0;
      bif.dtypei     = '0;
      bif.meta_datai = '0;
      set_rgb(10'h3FF, 10'h155, 10'h0AA);

      exp44[0] = '{16'h3FF, 16'h155, 16'h3FF, 16'h155};
      exp44[1] = '{16'h155, 16'h0AA, 16'h155, 16'h0AA};
      exp22[1] = '{16'h222, 16'h111, 16'h333, 16'h222};
      exp22[2] = '{16'h222, 16'h333, 16'h111, 16'h222};
      exp22[3] = '{16'h333, 16'h222, 16'h222, 16'h111};

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst.dvo", 32'(bif.dvo), 0);
      chk("rst.dtype", 32'(bif.dtypeo), 0);
      chk("rst.data", 32'(bif.datao), 0);
      chk("rst.cols", 32'(num_cols), 0);
      chk("rst.rows", 32'(num_rows), 0);
      chk("rst.err", 32'(protocol_err), 0);

      // 4x4 frame, phase 0
      idle();
      chk("lat.pre", 32'(bif.dvo), 0);
      send("t1.fs", FS, 16'hA5A5, 1'b1, 16'hA5A5);
      send("t1.hdr", HD, 16'h1234, 1'b1, 16'h1234);
      for (int row = 0; row < 4; row++) begin
         send("t1.rs", RS, 16'h0001, 1'b1, 16'h0001);
         for (int col = 0; col < 4; col++)
            send($sformatf("t1.px%0d%0d", row, col), PX, 16'hFFFF,
                 1'b1, exp44[row % 2][col]);
         send("t1.re", RE, 16'h0002, 1'b1, 16'h0002);
      end
      send("t1.fe", FE, 16'h0003, 1'b1, 16'h0003);
      chk("t1.cols", 32'(num_cols), 4);
      chk("t1.rows", 32'(num_rows), 4);
      chk("t1.err", 32'(protocol_err), 0);
      idle();
      chk("lat.post", 32'(bif.dvo), 0);

      // phase sweep on 2x2
      set_rgb(10'h111, 10'h222, 10'h333);
      for (int p = 1; p < 4; p++) begin
         phase = 2'(p);
         send("t2.fs", FS, 16'h0000, 1'b1, 16'h0000);
         phase = 2'd0;
         for (int row = 0; row < 2; row++) begin
            send("t2.rs", RS, 16'h0000, 1'b1, 16'h0000);
            for (int col = 0; col < 2; col++)
               send($sformatf("t2.p%0d.px%0d%0d", p, row, col), PX,
                    16'h0000, 1'b1, exp22[p][row * 2 + col]);
            send("t2.re", RE, 16'h0000, 1'b1, 16'h0000);
         end
         send("t2.fe", FE, 16'h0000, 1'b1, 16'h0000);
         chk("t2.rows", 32'(num_rows), 2);
         chk("t2.cols", 32'(num_cols), 2);
      end

      // disabled frame, enable raised mid-frame
      phase  = 2'd0;
      enable = 1'b0;
      send("t3.fs", FS, 16'h0055, 1'b0, 16'h0000);
      enable = 1'b1;
      send("t3.rs", RS, 16'h0000, 1'b0, 16'h0000);
      send("t3.px", PX, 16'h0000, 1'b0, 16'h0000);
      send("t3.re", RE, 16'h0000, 1'b0, 16'h0000);
      send("t3.fe", FE, 16'h0000, 1'b0, 16'h0000);
      chk("t3.rows", 32'(num_rows), 2);
      send("t3.fs2", FS, 16'h0066, 1'b1, 16'h0066);
      send("t3.rs2", RS, 16'h0000, 1'b1, 16'h0000);
      send("t3.px2", PX, 16'h0000, 1'b1, 16'h0111);
      send("t3.re2", RE, 16'h0000, 1'b1, 16'h0000);
      send("t3.fe2", FE, 16'h0000, 1'b1, 16'h0000);

      // inconsistent row lengths 4,4,3
      send("t4.fs", FS, 16'h0000, 1'b1, 16'h0000);
      for (int row = 0; row < 3; row++) begin
         send("t4.rs", RS, 16'h0000, 1'b1, 16'h0000);
         for (int col = 0; col < ((row == 2) ? 3 : 4); col++)
            send("t4.px", PX, 16'h0000, 1'b1,
                 (row % 2 == 0) ? ((col % 2 == 0) ? 16'h111 : 16'h222)
                                : ((col % 2 == 0) ? 16'h222 : 16'h333));
         send("t4.re", RE, 16'h0000, 1'b1, 16'h0000);
         chk($sformatf("t4.err%0d", row), 32'(protocol_err),
             (row == 2) ? 32'd1 : 32'd0);
      end
      chk("t4.cols", 32'(num_cols), 3);
      send("t4.fe", FE, 16'h0000, 1'b1, 16'h0000);
      chk("t4.rows", 32'(num_rows), 3);
      send("t4.fs2", FS, 16'h0000, 1'b1, 16'h0000);
      chk("t4.clr", 32'(protocol_err), 0);
      send("t4.fe2", FE, 16'h0000, 1'b1, 16'h0000);

      // stray pixel, then restart mid-row
      send("t5.fs", FS, 16'h0000, 1'b1, 16'h0000);
      send("t5.rs", RS, 16'h0000, 1'b1, 16'h0000);
      send("t5.px0", PX, 16'h0000, 1'b1, 16'h0111);
      send("t5.px1", PX, 16'h0000, 1'b1, 16'h0222);
      send("t5.re", RE, 16'h0000, 1'b1, 16'h0000);
      chk("t5.err0", 32'(protocol_err), 0);
      send("t5.stray", PX, 16'h0000, 1'b0, 16'h0000);
      chk("t5.err1", 32'(protocol_err), 1);
      send("t5.rs1", RS, 16'h0000, 1'b1, 16'h0000);
      send("t5.r1px", PX, 16'h0000, 1'b1, 16'h0222);
      send("t5.fsr", FS, 16'h0077, 1'b1, 16'h0077);
      chk("t5.err2", 32'(protocol_err), 1);
      send("t5.rs2", RS, 16'h0000, 1'b1, 16'h0000);
      send("t5.npx0", PX, 16'h0000, 1'b1, 16'h0111);
      send("t5.npx1", PX, 16'h0000, 1'b1, 16'h0222);
      send("t5.re2", RE, 16'h0000, 1'b1, 16'h0000);
      chk("t5.cols", 32'(num_cols), 2);

      // reset mid-row
      send("t6.rs", RS, 16'h0000, 1'b1, 16'h0000);
      send("t6.px", PX, 16'h0000, 1'b1, 16'h0222);
      reset = 1'b1;
      idle();
      reset = 1'b0;
      chk("t6.dvo", 32'(bif.dvo), 0);
      chk("t6.dtype", 32'(bif.dtypeo), 0);
      chk("t6.data", 32'(bif.datao), 0);
      chk("t6.cols", 32'(num_cols), 0);
      chk("t6.rows", 32'(num_rows), 0);
      chk("t6.err", 32'(protocol_err), 0);
      send("t6.px2", PX, 16'h0000, 1'b0, 16'h0000);
      send("t6.re", RE, 16'h0000, 1'b0, 16'h0000);
      send("t6.hdr", HD, 16'h00EE, 1'b0, 16'h0000);
      send("t6.fe", FE, 16'h0000, 1'b0, 16'h0000);
      send("t6.fs", FS, 16'h0099, 1'b1, 16'h0099);
      send("t6.rs2", RS, 16'h0000, 1'b1, 16'h0000);
      send("t6.px3", PX, 16'h0000, 1'b1, 16'h0111);
      idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
